// File: rtl/kv_filter_table.sv
// Hash-indexed flow table for DNS-response filtering: SUSPECT/ARREST status with tick-based aging.
// Three-stage pipeline: capture/index, read-modify-write of the table, registered reply.
// The read-modify-write happens in a single stage, so back-to-back requests to the same index
// always see the preceding write without any bypass network.
module kv_filter_table #(
  parameter int unsigned KEY_SIZE = 96,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned TS_W     = 16,
  parameter int unsigned TICK_DIV = 156250,
  parameter int unsigned AGE_MAX  = 1000
) (
  input  logic                clk156,
  input  logic                eth_rst,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [3:0]          in_flag,
  input  logic                in_valid,
  input  logic                tbl_clear,
  output logic                out_valid,
  output logic [3:0]          out_flag,
  output logic [7:0]          debug
);

  localparam int unsigned DEPTH  = 1 << IDX_W;
  localparam int unsigned NSLICE = (KEY_SIZE + IDX_W - 1) / IDX_W;
  localparam int unsigned PAD_W  = NSLICE * IDX_W;
  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // timebase
  logic [PRE_W-1:0] r_presc;
  logic [TS_W-1:0]  r_now;

  // stage 1: captured request
  logic                r1_valid;
  logic [KEY_SIZE-1:0] r1_key;
  logic [2:0]          r1_flag;
  logic [IDX_W-1:0]    r1_idx;

  // stage 2: computed reply {status, hit}
  logic       r2_valid;
  logic [2:0] r2_res;
  logic       r2_ins;

  // reply counters
  logic [3:0] r_arr_cnt;
  logic [3:0] r_ins_cnt;

  // table storage
  logic [DEPTH-1:0]    r_vld;
  logic [KEY_SIZE-1:0] r_tag [DEPTH];
  logic [1:0]          r_st  [DEPTH];
  logic [TS_W-1:0]     r_ts  [DEPTH];

  logic [PAD_W-1:0] w_key_pad;
  logic [IDX_W-1:0] w_idx;
  logic [TS_W-1:0]  w_age;
  logic             w_live;
  logic [1:0]       w_res_st;
  logic             w_hit;
  logic             w_ins;
  logic             w_wr_full;
  logic             w_wr_touch;
  logic [1:0]       w_new_st;
  logic             w_wr;
  logic             w_unused;

  // in_flag[3] carries no meaning for this stage
  assign w_unused  = in_flag[3];
  assign w_key_pad = PAD_W'(in_key);

  // XOR-fold of the key into a table index
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NSLICE; i++) begin
      w_idx = w_idx ^ w_key_pad[i*IDX_W +: IDX_W];
    end
  end

  // millisecond timebase: prescaler wrap advances 'now'
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      r_presc <= '0;
      r_now   <= '0;
    end else if (r_presc == PRE_W'(TICK_DIV - 1)) begin
      r_presc <= '0;
      r_now   <= r_now + TS_W'(1);
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // stage 1: register request and its index
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      r1_valid <= 1'b0;
    end else begin
      r1_valid <= in_valid;
    end
    r1_key  <= in_key;
    r1_flag <= in_flag[2:0];
    r1_idx  <= w_idx;
  end

  // modular age keeps entries live across the 'now' wrap
  assign w_age  = r_now - r_ts[r1_idx];
  assign w_live = r_vld[r1_idx] && (r_tag[r1_idx] == r1_key) && (w_age < TS_W'(AGE_MAX));

  // operation decode and reply for the request in stage 2
  always_comb begin
    w_res_st   = 2'b00;
    w_hit      = 1'b0;
    w_ins      = 1'b0;
    w_wr_full  = 1'b0;
    w_wr_touch = 1'b0;
    w_new_st   = r_st[r1_idx];
    if (w_live) begin
      w_hit    = 1'b1;
      w_res_st = r_st[r1_idx];
    end
    if (r1_flag[0]) begin
      case (r1_flag[2:1])
        2'b01: begin
          if (w_live) begin
            w_wr_touch = 1'b1;
          end else begin
            w_wr_full = 1'b1;
            w_new_st  = 2'b01;
            w_res_st  = 2'b01;
            w_ins     = 1'b1;
          end
        end
        2'b10: begin
          if (w_live) begin
            w_wr_touch = 1'b1;
            w_new_st   = 2'b10;
            w_res_st   = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  // a clear or reset on the write edge discards the write
  assign w_wr = r1_valid && !tbl_clear && !eth_rst && (w_wr_full || w_wr_touch);

  // entry valid bits
  always_ff @(posedge clk156) begin
    if (eth_rst || tbl_clear) begin
      r_vld <= '0;
    end else if (w_wr && w_wr_full) begin
      r_vld[r1_idx] <= 1'b1;
    end
  end

  // entry payload: tag only on insert, status/timestamp on any write
  always_ff @(posedge clk156) begin
    if (w_wr) begin
      if (w_wr_full) begin
        r_tag[r1_idx] <= r1_key;
      end
      r_st[r1_idx] <= w_new_st;
      r_ts[r1_idx] <= r_now;
    end
  end

  // stage 2: register the computed reply
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      r2_valid <= 1'b0;
      r2_res   <= '0;
      r2_ins   <= 1'b0;
    end else begin
      r2_valid <= r1_valid;
      r2_res   <= {w_res_st, w_hit};
      r2_ins   <= r1_valid && w_ins;
    end
  end

  // stage 3: reply outputs and counters
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      out_valid <= 1'b0;
      out_flag  <= '0;
      r_arr_cnt <= '0;
      r_ins_cnt <= '0;
    end else begin
      out_valid <= r2_valid;
      out_flag  <= r2_valid ? {1'b0, r2_res} : 4'b0000;
      if (r2_valid && (r2_res[2:1] == 2'b10)) begin
        r_arr_cnt <= r_arr_cnt + 4'd1;
      end
      if (r2_valid && r2_ins) begin
        r_ins_cnt <= r_ins_cnt + 4'd1;
      end
    end
  end

  assign debug = {r_ins_cnt, r_arr_cnt};

endmodule
